// File: rtl/hex_segment_decoder.sv
// Purpose: decode a synchronized, debounced active-low 7-segment pattern back to a digit.
// Latency: commit STABLE_CYCLES+1 edges after hex is sampled; no backpressure, all outputs registered.
// Optional: HEX_SEG_ALPHA_EN adds A-F as digits 10-15.
module hex_segment_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] hex,
   output logic [3:0] value,
   output logic       valid,
   output logic       err,
   output logic       changed
);

   typedef enum logic [1:0] {
      ST_BLANK = 2'b00,
      ST_DIGIT = 2'b01,
      ST_FAULT = 2'b10
   } state_t;

   localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
   localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);
   localparam logic [6:0] BLANK_PAT = 7'b1111111;

   logic [6:0] sync1_q, s_q;
   logic [6:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;
   logic       commit;
   logic [3:0] dec_digit;
   state_t     dec_cls;
   state_t     state_q, state_d;
   logic [3:0] value_q, value_d;
   logic       changed_q, changed_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= BLANK_PAT;
         s_q     <= BLANK_PAT;
         cand_q  <= BLANK_PAT;
         cnt_q   <= 8'd0;
      end else begin
         sync1_q <= hex;
         s_q     <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (s_q != cand_q) begin
         cand_d = s_q;
         cnt_d  = 8'd1;
      end else if (cnt_q < STABLE_C) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // A saturated counter sits at STABLE_C, so this fires once per stable run.
   assign commit = (s_q == cand_q) && (cnt_q == STABLE_M1);

   always_comb begin
      dec_digit = 4'd0;
      dec_cls   = ST_FAULT;
      case (cand_q)
         7'b1000000: begin dec_digit = 4'd0;  dec_cls = ST_DIGIT; end
         7'b1111001: begin dec_digit = 4'd1;  dec_cls = ST_DIGIT; end
         7'b0100100: begin dec_digit = 4'd2;  dec_cls = ST_DIGIT; end
         7'b0110000: begin dec_digit = 4'd3;  dec_cls = ST_DIGIT; end
         7'b0011001: begin dec_digit = 4'd4;  dec_cls = ST_DIGIT; end
         7'b0010010: begin dec_digit = 4'd5;  dec_cls = ST_DIGIT; end
         7'b0000010: begin dec_digit = 4'd6;  dec_cls = ST_DIGIT; end
         7'b1111000: begin dec_digit = 4'd7;  dec_cls = ST_DIGIT; end
         7'b0000000: begin dec_digit = 4'd8;  dec_cls = ST_DIGIT; end
         7'b0010000: begin dec_digit = 4'd9;  dec_cls = ST_DIGIT; end
`ifdef HEX_SEG_ALPHA_EN
         7'b0001000: begin dec_digit = 4'd10; dec_cls = ST_DIGIT; end
         7'b0000011: begin dec_digit = 4'd11; dec_cls = ST_DIGIT; end
         7'b1000110: begin dec_digit = 4'd12; dec_cls = ST_DIGIT; end
         7'b0100001: begin dec_digit = 4'd13; dec_cls = ST_DIGIT; end
         7'b0000110: begin dec_digit = 4'd14; dec_cls = ST_DIGIT; end
         7'b0001110: begin dec_digit = 4'd15; dec_cls = ST_DIGIT; end
`endif
         BLANK_PAT:  dec_cls = ST_BLANK;
         default:    dec_cls = ST_FAULT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_BLANK;
         value_q   <= 4'd0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         changed_q <= changed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (commit) begin
         state_d = dec_cls;
      end
   end

   always_comb begin
      value_d   = value_q;
      changed_d = 1'b0;
      if (commit && (dec_cls == ST_DIGIT)) begin
         value_d   = dec_digit;
         changed_d = (state_q != ST_DIGIT) || (dec_digit != value_q);
      end
   end

   // State encoding puts valid/err directly on flop bits.
   assign value   = value_q;
   assign valid   = state_q[0];
   assign err     = state_q[1];
   assign changed = changed_q;

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Directed bench for hex_segment_decoder: expected output sequences are queued
// when a pattern is driven and popped one per clock as the DUT responds.
module tb_hex_segment_decoder;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] hex;
   logic [3:0] value;
   logic       valid;
   logic       err;
   logic       changed;

   hex_segment_decoder #(.STABLE_CYCLES(S)) dut (
      .clk     (clk),
      .reset   (reset),
      .hex     (hex),
      .value   (value),
      .valid   (valid),
      .err     (err),
      .changed (changed)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] value;
      logic       valid;
      logic       err;
      logic       changed;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [3:0] m_value;
   logic       m_valid;
   logic       m_err;
   logic [6:0] seg_tab [16];

`ifdef HEX_SEG_ALPHA_EN
   localparam int NDIG = 16;
`else
   localparam int NDIG = 10;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [3:0] v, input logic vl,
                       input logic er, input logic ch);
      exp_t e;
      e.tag = tag; e.value = v; e.valid = vl; e.err = er; e.changed = ch;
      sb.push_back(e);
   endtask

   task automatic check_front();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert ({value, valid, err, changed} === {e.value, e.valid, e.err, e.changed})
      else begin
         failures++;
         $error("FAIL %s observed value=%0d valid=%b err=%b changed=%b expected value=%0d valid=%b err=%b changed=%b",
                e.tag, value, valid, err, changed, e.value, e.valid, e.err, e.changed);
      end
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         tick();
         check_front();
      end
   endtask

   task automatic push_hold(input string tag, input int n);
      for (int i = 0; i < n; i++) push(tag, m_value, m_valid, m_err, 1'b0);
   endtask

   // Drive a new pattern; its commit is expected on the (S+2)-th edge.
   task automatic apply(input logic [6:0] pat, input string tag);
      logic       is_dig;
      logic [3:0] d;
      logic       ch;
      is_dig = 1'b0;
      d      = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (seg_tab[i] == pat) begin
            is_dig = 1'b1;
            d      = 4'(i);
         end
      end
      hex = pat;
      push_hold({tag, "_pre"}, S + 1);
      ch = 1'b0;
      if (is_dig) begin
         ch      = !m_valid || (d != m_value);
         m_value = d;
         m_valid = 1'b1;
         m_err   = 1'b0;
      end else if (pat == 7'b1111111) begin
         m_valid = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_valid = 1'b0;
         m_err   = 1'b1;
      end
      push({tag, "_commit"}, m_value, m_valid, m_err, ch);
      push({tag, "_post"}, m_value, m_valid, m_err, 1'b0);
      drain();
   endtask

   task automatic glitch(input logic [6:0] gpat, input int len,
                         input logic [6:0] base, input string tag);
      hex = gpat;
      push_hold({tag, "_during"}, len);
      drain();
      hex = base;
      push_hold({tag, "_after"}, S + 4);
      drain();
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      m_value = 4'd0;
      m_valid = 1'b0;
      m_err   = 1'b0;

      reset = 1'b1;
      hex   = seg_tab[0];
      #2;
      push("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
      check_front();
      push_hold("reset_held", 3);
      drain();
      @(negedge clk);
      reset = 1'b0;
      apply(seg_tab[0], "first_zero");

      apply(seg_tab[3], "step_to_3");
      push_hold("hold_3", 20);
      drain();

      glitch(seg_tab[2], 2, seg_tab[3], "glitch2");
      glitch(seg_tab[2], S - 1, seg_tab[3], "glitch_max");

      apply(7'b0000011, "alpha_b");
      apply(7'b1111111, "blank");
      apply(seg_tab[3], "reapply_3");

      for (int d = 0; d < 16; d++) apply(seg_tab[d], $sformatf("sweep%0d", d));
      apply(7'b0101010, "illegal");
      apply(7'b1111111, "blank2");

      // Interrupt a run of 5 at cnt = 3 with reset.
      hex = seg_tab[5];
      push_hold("pre_reset_run", S + 1);
      drain();
      #1;
      reset = 1'b1;
      #1;
      m_value = 4'd0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      push("midrun_reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
      check_front();
      push_hold("midrun_reset_held", 2);
      drain();
      @(negedge clk);
      reset = 1'b0;
      apply(seg_tab[5], "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
